irig_b_tx: RTL
==============

Name: irig_b_tx

Overview:
- IRIG-B000 (DC level-shift) transmitter: the encoder counterpart of the existing IRIG-B receive and decode path.
- On each 1PPS pulse it snapshots a loaded time-of-year (second/minute/hour/day/year) and serialises one 100-bit, 1-second frame on IrigbOut.
- Bit rate is 100 bps, with BCD time fields and straight-binary seconds-of-day (SBS).
- Sits in the time top, driven by the local disciplined pps and the seconds/time registers; it feeds the IRIG-B output driver and loopback tests of the receiver.

Parameters:
CLK_FREQ_HZ, 125000000, clk frequency; must be divisible by 1000.
BIT_CLKS, CLK_FREQ_HZ/100, clocks per 10 ms bit cell.
ZERO_CLKS, CLK_FREQ_HZ/500, high time for a '0' (2 ms).
ONE_CLKS, CLK_FREQ_HZ/200, high time for a '1' (5 ms).
MARK_CLKS, CLK_FREQ_HZ*2/250, high time for a marker (8 ms).
SBS_EN, 1, 1 = encode SBS in bits 80-97; 0 = those bits are zeros.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous reset, active-low.
pps_in  in  1  single-cycle on-time pulse in the clk domain.
time_vld  in  1  single-cycle strobe; load tx_* into the shadow registers.
tx_second  in  7  binary, 0-59.
tx_minute  in  7  binary, 0-59.
tx_hour  in  6  binary, 0-23.
tx_day  in  10  binary day of year, 1-366.
tx_year  in  8  binary, 0-99.
IrigbOut  out  1  IRIG-B DC level output.
frame_active  out  1  high while a frame is being sent.
frame_done  out  1  one-cycle pulse at the end of bit 99.
time_err  out  1  one-cycle pulse when time_vld carries an out-of-range field.
pps_resync  out  1  one-cycle pulse when pps_in arrives while frame_active.

Behaviour:
- Reset (rst=0 at a clk edge): all outputs 0; shadow_valid=0; FSM=IDLE; counters 0; shadow time fields 0.
- Load: time_vld with all fields in range -> shadow time updated next cycle and shadow_valid=1.
  - Any field out of range (day 0 or >366 included) -> shadow unchanged, time_err=1 for one cycle.
- Frame start: pps_in with shadow_valid=1 snapshots the shadow into the frame register (100 symbols, 2-bit code ZERO/ONE/MARK).
  - The same cycle sets bit_idx=0 and cell_cnt=0.
  - IrigbOut rises exactly one clk after the pps_in cycle.
  - pps_in with shadow_valid=0 is ignored.
- Simultaneous time_vld and pps_in: the frame uses the previous shadow; the new value applies to the next frame.
- FSM states: IDLE (IrigbOut=0) -> SEND on accepted pps_in.
  - SEND: cell_cnt counts 0..BIT_CLKS-1.
  - IrigbOut=1 while cell_cnt < high time of the current symbol, else 0.
  - At cell_cnt=BIT_CLKS-1: bit_idx++.
  - At bit_idx=99 and the last clk of its cell: frame_done=1 and FSM goes to IDLE.
  - Output stays low until the next pps_in; no free-running frames.
- pps_in during SEND (early or late pps): abort the current frame, pulse pps_resync, and restart at bit 0 with the current shadow.
  - Same one-cycle latency as a normal start; no frame_done for the aborted frame.
- Frame map (bit index: content). BCD is LSB first; all unlisted bits are ZERO.
  - 0: MARK (Pr); 9,19,29,...,99: MARK (P1..P0).
  - 1-4 sec units; 6-8 sec tens.
  - 10-13 min units; 15-17 min tens.
  - 20-23 hour units; 25-26 hour tens.
  - 30-33 day units; 35-38 day tens; 40-41 day hundreds.
  - 50-53 year units; 55-58 year tens.
  - 80-88 SBS[8:0]; 90-97 SBS[16:9].
  - SBS = hour*3600 + minute*60 + second (17 bits, max 86399), computed at load, not at pps.
- Binary-to-BCD and SBS computation are complete before shadow_valid asserts.
  - Load latency ≤ 4 clk; time_vld is never issued faster than once per 4 clk.
  - Arithmetic is unsigned; no truncation for in-range inputs.
- Reset mid-frame: IrigbOut=0 at the next edge; a frame resumes only after a new time_vld and then pps_in.

Decomposition:
- Shared package irig_b_pkg holds:
  - symbol enum: ZERO=0, ONE=1, MARK=2;
  - FRAME_BITS=100;
  - marker index list;
  - field bit positions;
  - range limits (59/59/23/366/99).
- Sub-module irig_b_frame_build: range check, binary-to-BCD conversion, SBS multiply-add, and packing into the 200-bit symbol vector.
- Top level holds the FSM and the cell/bit counters.

Test Plan (CLK_FREQ_HZ=10000 gives BIT_CLKS=100, ZERO=20, ONE=50, MARK=80):
- Load 23:59:59, day 366, year 99, then pps_in -> bit 0 high 80 clk; bits 1-4 high 50/20/20/50 clk (sec units 9); SBS bits 80-88 encode 86399 & 0x1FF = 0x17F; frame_done 10000 clk after start.
- pps_in before any time_vld -> IrigbOut stays 0 and frame_active stays 0.
- time_vld with tx_minute=60 -> time_err pulse; next frame still carries the previously loaded minute.
- pps_in at bit 57 of a frame -> pps_resync pulse; IrigbOut rises 1 clk later with an 80-clk marker; no frame_done for the aborted frame.
- time_vld and pps_in in the same cycle (old 00:00:01, new 00:00:02) -> frame encodes second 1; following frame encodes second 2.
- rst=0 for 1 clk at bit 40 -> IrigbOut=0 next clk; no output until time_vld then pps_in; with SBS_EN=0, bits 80-97 are all 20-clk zeros.

Source files
------------

// File: rtl/irig_b_pkg.sv
// Shared definitions for the IRIG-B000 transmit path: symbol coding, frame layout and field limits.
package irig_b_pkg;

    // Two-bit symbol code stored per frame bit.
    typedef enum logic [1:0] {
        SymZero = 2'd0,
        SymOne  = 2'd1,
        SymMark = 2'd2
    } symbol_e;

    typedef enum logic {
        StIdle,
        StSend
    } tx_state_e;

    localparam int unsigned FRAME_BITS = 100;
    localparam int unsigned IDX_W      = 7;
    localparam int unsigned SYM_W      = 2;

    // Reference marker Pr at bit 0, then P1..P0 at the end of every 10-bit group.
    localparam int unsigned NUM_MARKERS = 11;
    localparam int unsigned MARKER_POS [NUM_MARKERS] = '{0, 9, 19, 29, 39, 49, 59, 69, 79, 89, 99};

    // LSB positions of the BCD and SBS fields within the frame.
    localparam int unsigned SEC_U_POS  = 1;
    localparam int unsigned SEC_T_POS  = 6;
    localparam int unsigned MIN_U_POS  = 10;
    localparam int unsigned MIN_T_POS  = 15;
    localparam int unsigned HOUR_U_POS = 20;
    localparam int unsigned HOUR_T_POS = 25;
    localparam int unsigned DAY_U_POS  = 30;
    localparam int unsigned DAY_T_POS  = 35;
    localparam int unsigned DAY_H_POS  = 40;
    localparam int unsigned YEAR_U_POS = 50;
    localparam int unsigned YEAR_T_POS = 55;
    localparam int unsigned SBS_LO_POS = 80;
    localparam int unsigned SBS_HI_POS = 90;

    // Accepted input ranges.
    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HOUR_MAX = 23;
    localparam int unsigned DAY_MIN  = 1;
    localparam int unsigned DAY_MAX  = 366;
    localparam int unsigned YEAR_MAX = 99;

    function automatic logic is_marker(input int unsigned idx);
        logic hit;
        hit = 1'b0;
        for (int unsigned k = 0; k < NUM_MARKERS; k++) begin
            if (MARKER_POS[k] == idx) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/irig_b_frame_build.sv
// Range-checks a time load, holds the shadow time and turns it into a 100-symbol frame image.
module irig_b_frame_build
    import irig_b_pkg::*;
#(
    parameter bit SBS_EN = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              time_vld,
    input  logic [6:0]                        tx_second,
    input  logic [6:0]                        tx_minute,
    input  logic [5:0]                        tx_hour,
    input  logic [9:0]                        tx_day,
    input  logic [7:0]                        tx_year,
    output logic [FRAME_BITS-1:0][SYM_W-1:0]  shadow_sym,
    output logic                              shadow_valid,
    output logic                              time_err
);

    logic       fields_ok;
    logic       load_q;
    logic [6:0] shadow_second;
    logic [6:0] shadow_minute;
    logic [5:0] shadow_hour;
    logic [9:0] shadow_day;
    logic [7:0] shadow_year;

    logic [16:0]                       sbs;
    logic [FRAME_BITS-1:0]             data;
    logic [FRAME_BITS-1:0][SYM_W-1:0]  sym_d;

    assign fields_ok = (tx_second <= 7'(SEC_MAX)) && (tx_minute <= 7'(MIN_MAX)) &&
                       (tx_hour <= 6'(HOUR_MAX)) && (tx_day >= 10'(DAY_MIN)) &&
                       (tx_day <= 10'(DAY_MAX)) && (tx_year <= 8'(YEAR_MAX));

    // Stage 1: capture in-range time into the shadow fields, flag bad loads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            load_q        <= 1'b0;
            time_err      <= 1'b0;
            shadow_second <= '0;
            shadow_minute <= '0;
            shadow_hour   <= '0;
            shadow_day    <= '0;
            shadow_year   <= '0;
        end else begin
            load_q   <= time_vld && fields_ok;
            time_err <= time_vld && !fields_ok;
            if (time_vld && fields_ok) begin
                shadow_second <= tx_second;
                shadow_minute <= tx_minute;
                shadow_hour   <= tx_hour;
                shadow_day    <= tx_day;
                shadow_year   <= tx_year;
            end
        end
    end

    // BCD split, seconds-of-day and symbol packing from the shadow fields.
    always_comb begin
        sbs  = 17'(shadow_hour) * 17'd3600 + 17'(shadow_minute) * 17'd60 + 17'(shadow_second);
        data = '0;
        data[SEC_U_POS  +: 4] = 4'(shadow_second % 7'd10);
        data[SEC_T_POS  +: 3] = 3'(shadow_second / 7'd10);
        data[MIN_U_POS  +: 4] = 4'(shadow_minute % 7'd10);
        data[MIN_T_POS  +: 3] = 3'(shadow_minute / 7'd10);
        data[HOUR_U_POS +: 4] = 4'(shadow_hour % 6'd10);
        data[HOUR_T_POS +: 2] = 2'(shadow_hour / 6'd10);
        data[DAY_U_POS  +: 4] = 4'(shadow_day % 10'd10);
        data[DAY_T_POS  +: 4] = 4'((shadow_day / 10'd10) % 10'd10);
        data[DAY_H_POS  +: 2] = 2'(shadow_day / 10'd100);
        data[YEAR_U_POS +: 4] = 4'(shadow_year % 8'd10);
        data[YEAR_T_POS +: 4] = 4'(shadow_year / 8'd10);
        if (SBS_EN) begin
            data[SBS_LO_POS +: 9] = sbs[8:0];
            data[SBS_HI_POS +: 8] = sbs[16:9];
        end
        for (int unsigned i = 0; i < FRAME_BITS; i++) begin
            sym_d[i] = is_marker(i) ? SymMark : (data[i] ? SymOne : SymZero);
        end
    end

    // Stage 2: publish the finished frame image; a pps in between still sees the old one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow_sym   <= '0;
            shadow_valid <= 1'b0;
        end else if (load_q) begin
            shadow_sym   <= sym_d;
            shadow_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/irig_b_tx.sv
// IRIG-B000 DC level-shift transmitter: one 100-bit frame per accepted pps pulse.
module irig_b_tx
    import irig_b_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 125000000,
    parameter bit          SBS_EN      = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pps_in,
    input  logic       time_vld,
    input  logic [6:0] tx_second,
    input  logic [6:0] tx_minute,
    input  logic [5:0] tx_hour,
    input  logic [9:0] tx_day,
    input  logic [7:0] tx_year,
    output logic       IrigbOut,
    output logic       frame_active,
    output logic       frame_done,
    output logic       time_err,
    output logic       pps_resync
);

    localparam int unsigned BIT_CLKS  = CLK_FREQ_HZ / 100;
    localparam int unsigned ZERO_CLKS = CLK_FREQ_HZ / 500;
    localparam int unsigned ONE_CLKS  = CLK_FREQ_HZ / 200;
    localparam int unsigned MARK_CLKS = CLK_FREQ_HZ * 2 / 250;
    localparam int unsigned CNT_W     = $clog2(BIT_CLKS);

    logic [FRAME_BITS-1:0][SYM_W-1:0] shadow_sym;
    logic                             shadow_valid;

    tx_state_e                        state_q, state_d;
    logic [CNT_W-1:0]                 cell_q, cell_d;
    logic [IDX_W-1:0]                 bit_q, bit_d;
    logic [FRAME_BITS-1:0][SYM_W-1:0] frame_q, frame_d;
    logic                             done_q, done_d;
    logic                             resync_q, resync_d;
    logic [SYM_W-1:0]                 cur_sym;
    logic [CNT_W-1:0]                 high_clks;

    irig_b_frame_build #(
        .SBS_EN (SBS_EN)
    ) u_frame_build (
        .clk          (clk),
        .rst          (rst),
        .time_vld     (time_vld),
        .tx_second    (tx_second),
        .tx_minute    (tx_minute),
        .tx_hour      (tx_hour),
        .tx_day       (tx_day),
        .tx_year      (tx_year),
        .shadow_sym   (shadow_sym),
        .shadow_valid (shadow_valid),
        .time_err     (time_err)
    );

    // State, counters and frame register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            cell_q   <= '0;
            bit_q    <= '0;
            frame_q  <= '0;
            done_q   <= 1'b0;
            resync_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cell_q   <= cell_d;
            bit_q    <= bit_d;
            frame_q  <= frame_d;
            done_q   <= done_d;
            resync_q <= resync_d;
        end
    end

    // Next state: an accepted pps always (re)starts at bit 0, even mid-frame.
    always_comb begin
        state_d  = state_q;
        cell_d   = cell_q;
        bit_d    = bit_q;
        frame_d  = frame_q;
        done_d   = 1'b0;
        resync_d = 1'b0;
        if (pps_in && shadow_valid) begin
            state_d  = StSend;
            cell_d   = '0;
            bit_d    = '0;
            frame_d  = shadow_sym;
            resync_d = (state_q == StSend);
        end else if (state_q == StSend) begin
            if (cell_q == CNT_W'(BIT_CLKS - 1)) begin
                cell_d = '0;
                if (bit_q == IDX_W'(FRAME_BITS - 1)) begin
                    state_d = StIdle;
                    bit_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end else begin
                cell_d = cell_q + 1'b1;
            end
        end
    end

    // High time of the symbol currently on the wire.
    always_comb begin
        cur_sym = frame_q[bit_q];
        case (cur_sym)
            SymMark: high_clks = CNT_W'(MARK_CLKS);
            SymOne:  high_clks = CNT_W'(ONE_CLKS);
            default: high_clks = CNT_W'(ZERO_CLKS);
        endcase
    end

    assign IrigbOut     = (state_q == StSend) && (cell_q < high_clks);
    assign frame_active = (state_q == StSend);
    assign frame_done   = done_q;
    assign pps_resync   = resync_q;

endmodule
